// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-port SPI arbiter.
package spi_arb_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_DBG = 1'b1
  } grant_e;

  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/spi_arb_timeout.sv
// WAIT-phase watchdog: counts enabled cycles and flags the last allowed one.
module spi_arb_timeout
  import spi_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  // Saturates at the limit so a stalled enable can never wrap around.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between a CPU port and a debug port.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_i,
  input  logic              cpu_rwb_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_rwb_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  output logic              spi_start_o,
  output logic              spi_rwb_o,
  output logic [ADDR_W-1:0] spi_addr_o,
  output logic [DATA_W-1:0] spi_wdata_o,
  input  logic              spi_busy_i,
  input  logic              spi_done_i,
  input  logic [DATA_W-1:0] spi_rdata_i,
  output logic              grant_o,
  output logic [1:0]        state_o
);

  arb_state_e        state_reg, state_next;
  grant_e            grant_reg, grant_next;
  logic              start_reg, start_next;
  logic              rwb_reg, rwb_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              cpu_ack_reg, cpu_ack_next, dbg_ack_reg, dbg_ack_next;
  logic              cpu_err_reg, cpu_err_next, dbg_err_reg, dbg_err_next;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next, dbg_rdata_reg, dbg_rdata_next;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              expired;

  spi_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg == ST_ISSUE),
    .enable  (state_reg == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      grant_reg     <= GRANT_DBG;
      start_reg     <= 1'b0;
      rwb_reg       <= 1'b1;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_ack_reg   <= 1'b0;
      dbg_ack_reg   <= 1'b0;
      cpu_err_reg   <= 1'b0;
      dbg_err_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      start_reg     <= start_next;
      rwb_reg       <= rwb_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cpu_ack_reg   <= cpu_ack_next;
      dbg_ack_reg   <= dbg_ack_next;
      cpu_err_reg   <= cpu_err_next;
      dbg_err_reg   <= dbg_err_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dbg_rdata_reg <= dbg_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    start_next     = 1'b0;
    rwb_next       = rwb_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cpu_ack_next   = 1'b0;
    dbg_ack_next   = 1'b0;
    cpu_err_next   = 1'b0;
    dbg_err_next   = 1'b0;
    cpu_rdata_next = cpu_rdata_reg;
    dbg_rdata_next = dbg_rdata_reg;
    resp_rdata     = '0;
    resp_err       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if ((cpu_req_i || dbg_req_i) && !spi_busy_i) begin
          state_next = ST_ISSUE;
          start_next = 1'b1;
          // On a tie, the port that did not own the master last time goes first.
          if (cpu_req_i && dbg_req_i) begin
            grant_next = (grant_reg == GRANT_CPU) ? GRANT_DBG : GRANT_CPU;
          end else if (dbg_req_i) begin
            grant_next = GRANT_DBG;
          end else begin
            grant_next = GRANT_CPU;
          end
          if (grant_next == GRANT_DBG) begin
            rwb_next   = dbg_rwb_i;
            addr_next  = dbg_addr_i;
            wdata_next = dbg_wdata_i;
          end else begin
            rwb_next   = cpu_rwb_i;
            addr_next  = cpu_addr_i;
            wdata_next = cpu_wdata_i;
          end
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        // A done arriving on the expiry cycle still counts as a good completion.
        if (spi_done_i || expired) begin
          state_next = ST_RESP;
          resp_err   = !spi_done_i;
          resp_rdata = (spi_done_i && rwb_reg) ? spi_rdata_i : '0;
          if (grant_reg == GRANT_DBG) begin
            dbg_ack_next   = 1'b1;
            dbg_err_next   = resp_err;
            dbg_rdata_next = resp_rdata;
          end else begin
            cpu_ack_next   = 1'b1;
            cpu_err_next   = resp_err;
            cpu_rdata_next = resp_rdata;
          end
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign cpu_ack_o   = cpu_ack_reg;
  assign cpu_err_o   = cpu_err_reg;
  assign cpu_rdata_o = cpu_rdata_reg;
  assign dbg_ack_o   = dbg_ack_reg;
  assign dbg_err_o   = dbg_err_reg;
  assign dbg_rdata_o = dbg_rdata_reg;
  assign spi_start_o = start_reg;
  assign spi_rwb_o   = rwb_reg;
  assign spi_addr_o  = addr_reg;
  assign spi_wdata_o = wdata_reg;
  assign grant_o     = grant_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: stimulus pushes predicted starts/acks, a monitor pops and compares.
module tb_spi_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req_i, cpu_rwb_i, dbg_req_i, dbg_rwb_i;
  logic [AW-1:0] cpu_addr_i, dbg_addr_i;
  logic [DW-1:0] cpu_wdata_i, dbg_wdata_i;
  logic          cpu_ack_o, cpu_err_o, dbg_ack_o, dbg_err_o;
  logic [DW-1:0] cpu_rdata_o, dbg_rdata_o;
  logic          spi_start_o, spi_rwb_o;
  logic [AW-1:0] spi_addr_o;
  logic [DW-1:0] spi_wdata_o;
  logic          spi_busy_i, spi_done_i;
  logic [DW-1:0] spi_rdata_i;
  logic          grant_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  spi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req_i), .cpu_rwb_i(cpu_rwb_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .cpu_err_o(cpu_err_o),
    .dbg_req_i(dbg_req_i), .dbg_rwb_i(dbg_rwb_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
    .dbg_err_o(dbg_err_o),
    .spi_start_o(spi_start_o), .spi_rwb_o(spi_rwb_o), .spi_addr_o(spi_addr_o),
    .spi_wdata_o(spi_wdata_o), .spi_busy_i(spi_busy_i), .spi_done_i(spi_done_i),
    .spi_rdata_i(spi_rdata_i), .grant_o(grant_o), .state_o(state_o)
  );

  typedef struct {
    logic          port;
    logic          rwb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } start_t;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } ack_t;

  start_t start_q[$];
  ack_t   ack_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     start_cyc = 0;
  logic   prev_start = 1'b0;
  logic   last_port;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes predictions whenever the DUT shows a start or an ack.
  always @(negedge clk) begin : monitor
    start_t s;
    ack_t   a;
    cyc++;
    if (!reset) begin
      chk("ack_exclusive", longint'(cpu_ack_o & dbg_ack_o), 0);
      chk("cpu_err_outside_ack", longint'(cpu_err_o & ~cpu_ack_o), 0);
      chk("dbg_err_outside_ack", longint'(dbg_err_o & ~dbg_ack_o), 0);
      if (spi_start_o) begin
        chk("start_single_cycle", longint'(prev_start), 0);
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start actual=1 expected=0 (t=%0t)", $time);
        end else begin
          s = start_q.pop_front();
          chk("start_grant", longint'(grant_o), longint'(s.port));
          chk("start_rwb", longint'(spi_rwb_o), longint'(s.rwb));
          chk("start_addr", longint'(spi_addr_o), longint'(s.addr));
          chk("start_wdata", longint'(spi_wdata_o), longint'(s.wdata));
          $display("start port=%0d rwb=%0d addr=0x%04h wdata=0x%08h", grant_o, spi_rwb_o, spi_addr_o, spi_wdata_o);
        end
        start_cyc = cyc;
      end
      if (cpu_ack_o || dbg_ack_o) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack actual=1 expected=0 (t=%0t)", $time);
        end else begin
          a = ack_q.pop_front();
          chk("ack_port", longint'(dbg_ack_o), longint'(a.port));
          chk("ack_rdata", longint'(dbg_ack_o ? dbg_rdata_o : cpu_rdata_o), longint'(a.rdata));
          chk("ack_err", longint'(dbg_ack_o ? dbg_err_o : cpu_err_o), longint'(a.err));
          chk("ack_latency", longint'(cyc - start_cyc), longint'(a.lat));
          $display("ack port=%0d rdata=0x%08h err=%0d lat=%0d", dbg_ack_o,
                   dbg_ack_o ? dbg_rdata_o : cpu_rdata_o, dbg_ack_o ? dbg_err_o : cpu_err_o, cyc - start_cyc);
        end
      end
    end
    prev_start = spi_start_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, longint'(state_o), 0);
    chk({tag, "_start"}, longint'(spi_start_o), 0);
    chk({tag, "_acks"}, longint'({cpu_ack_o, dbg_ack_o}), 0);
    chk({tag, "_errs"}, longint'({cpu_err_o, dbg_err_o}), 0);
    chk({tag, "_cpu_rdata"}, longint'(cpu_rdata_o), 0);
    chk({tag, "_dbg_rdata"}, longint'(dbg_rdata_o), 0);
    chk({tag, "_addr"}, longint'(spi_addr_o), 0);
    chk({tag, "_wdata"}, longint'(spi_wdata_o), 0);
    chk({tag, "_rwb"}, longint'(spi_rwb_o), 1);
    chk({tag, "_grant"}, longint'(grant_o), 1);
  endtask

  task automatic wait_for(input bit want_ack, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (want_ack ? (cpu_ack_o || dbg_ack_o) : spi_start_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=none expected=pulse (t=%0t)", want_ack ? "ack" : "start", $time);
    end
  endtask

  // Called in the start cycle; done is raised during WAIT cycle d (d > TO: never).
  task automatic serve(input int d, input logic [DW-1:0] r);
    if (d <= TO) begin
      repeat (d) tick();
      spi_done_i  = 1'b1;
      spi_rdata_i = r;
      tick();
      spi_done_i  = 1'b0;
      spi_rdata_i = $urandom;
    end
  endtask

  task automatic run_group(input bit use_cpu, input bit use_dbg,
                           input logic c_rwb, input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                           input logic d_rwb, input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wd,
                           input int d0, input logic [DW-1:0] r0, input int d1, input logic [DW-1:0] r1,
                           input int busy_cyc);
    logic          order[2];
    int            dd[2];
    logic [DW-1:0] rr[2];
    int            n;
    bit            ok;
    start_t        s;
    ack_t          a;
    if (use_cpu && use_dbg) begin
      order[0] = ~last_port;
      order[1] = last_port;
      n = 2;
    end else begin
      order[0] = use_dbg;
      order[1] = use_dbg;
      n = 1;
    end
    dd[0] = d0; dd[1] = d1; rr[0] = r0; rr[1] = r1;
    for (int i = 0; i < n; i++) begin
      s.port  = order[i];
      s.rwb   = order[i] ? d_rwb : c_rwb;
      s.addr  = order[i] ? d_addr : c_addr;
      s.wdata = order[i] ? d_wd : c_wd;
      start_q.push_back(s);
      a.port  = order[i];
      a.err   = (dd[i] > TO);
      a.rdata = (a.err || !s.rwb) ? '0 : rr[i];
      a.lat   = ((dd[i] > TO) ? TO : dd[i]) + 1;
      ack_q.push_back(a);
    end
    last_port = order[n-1];
    cpu_rwb_i = c_rwb; cpu_addr_i = c_addr; cpu_wdata_i = c_wd;
    dbg_rwb_i = d_rwb; dbg_addr_i = d_addr; dbg_wdata_i = d_wd;
    spi_busy_i = (busy_cyc > 0);
    cpu_req_i = use_cpu;
    dbg_req_i = use_dbg;
    for (int b = 0; b < busy_cyc; b++) begin
      tick();
      chk("no_start_while_busy", longint'(spi_start_o), 0);
    end
    spi_busy_i = 1'b0;
    tick();
    chk("req_to_start_latency", longint'(spi_start_o), 1);
    for (int i = 0; i < n; i++) begin
      wait_for(1'b0, ok);
      if (!ok) break;
      serve(dd[i], rr[i]);
      wait_for(1'b1, ok);
      if (!ok) break;
      if (cpu_ack_o) cpu_req_i = 1'b0;
      if (dbg_ack_o) dbg_req_i = 1'b0;
    end
    cpu_req_i = 1'b0;
    dbg_req_i = 1'b0;
    tick();
  endtask

  task automatic idle_gap(input bit stray_done);
    if (stray_done) begin
      spi_done_i  = 1'b1;
      spi_rdata_i = $urandom;
      tick();
      spi_done_i  = 1'b0;
    end
    tick();
  endtask

  task automatic reset_mid_wait();
    start_t s;
    s.port = 1'b0; s.rwb = 1'b1; s.addr = 16'h0BAD; s.wdata = 32'h1234_5678;
    start_q.push_back(s);
    cpu_rwb_i = 1'b1; cpu_addr_i = 16'h0BAD; cpu_wdata_i = 32'h1234_5678;
    cpu_req_i = 1'b1;
    tick();
    chk("rst_test_start", longint'(spi_start_o), 1);
    tick();
    tick();
    chk("rst_test_in_wait", longint'(state_o), 2);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    cpu_req_i = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    last_port = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("no_ack_after_reset", longint'(cpu_ack_o | dbg_ack_o), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_req_i = 1'b0; cpu_rwb_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    dbg_req_i = 1'b0; dbg_rwb_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
    spi_busy_i = 1'b0; spi_done_i = 1'b0; spi_rdata_i = $urandom;
    last_port = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // CPU read, done after 5 WAIT cycles.
    run_group(1, 0, 1, 16'h0010, 32'h0, 0, 16'h0, 32'h0, 5, 32'hDEAD_BEEF, 0, 32'h0, 0);
    idle_gap(0);
    // Two simultaneous requests back to back: debug first after a CPU grant.
    run_group(1, 1, 1, 16'h0020, 32'h0, 1, 16'h0030, 32'h0, 3, 32'h1111_2222, 2, 32'h3333_4444, 0);
    idle_gap(0);
    run_group(1, 1, 0, 16'h0040, 32'hAAAA_0001, 1, 16'h0050, 32'h0, 4, 32'h5555_6666, 6, 32'h7777_8888, 0);
    idle_gap(1);
    // Debug write with no done: times out after TO WAIT cycles.
    run_group(0, 1, 1, 16'h0, 32'h0, 0, 16'h0100, 32'hCAFE_F00D, TO + 5, 32'h9999_9999, 0, 32'h0, 0);
    idle_gap(0);
    // Done on the expiry cycle.
    run_group(1, 0, 1, 16'h0200, 32'h0, 0, 16'h0, 32'h0, TO, 32'h0BAD_CAFE, 0, 32'h0, 0);
    idle_gap(0);
    // Busy master holds off the start.
    run_group(1, 0, 1, 16'h0300, 32'h0, 0, 16'h0, 32'h0, 2, 32'hFEED_FACE, 0, 32'h0, 10);
    idle_gap(0);
    reset_mid_wait();
    // First tie after reset goes to the CPU.
    run_group(1, 1, 1, 16'h0400, 32'h0, 1, 16'h0500, 32'h0, 1, 32'h0102_0304, 3, 32'h0506_0708, 0);
    idle_gap(0);

    for (int t = 0; t < 40; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      run_group(mode != 1, mode != 0,
                1'($urandom), AW'($urandom), $urandom,
                1'($urandom), AW'($urandom), $urandom,
                $urandom_range(1, TO + 3), $urandom, $urandom_range(1, TO + 3), $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      idle_gap($urandom_range(0, 1) == 1);
    end

    repeat (5) tick();
    chk("start_queue_drained", longint'(start_q.size()), 0);
    chk("ack_queue_drained", longint'(ack_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
